// File: rtl/acc_dump_reader.sv
// acc_dump_reader: captures I/Q integrate-and-dump results, scales and
// saturates them, tags each with its frequency-step index and streams them
// out through a first-word-fall-through buffer with valid/ready handshake.
module acc_dump_reader #(
    parameter int IN_W    = 48,
    parameter int OUT_W   = 32,
    parameter int SHIFT   = 8,
    parameter int N_STEPS = 64,
    parameter int STEP_W  = 10,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   acc_i,
    input  logic [IN_W-1:0]   acc_q,
    input  logic              acc_valid,
    input  logic              sweep_start,
    input  logic              clear_ovf,
    output logic [OUT_W-1:0]  m_i,
    output logic [OUT_W-1:0]  m_q,
    output logic [STEP_W-1:0] m_step,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   fill,
    output logic              overflow
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORD_W = 1 + STEP_W + 2 * OUT_W;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(N_STEPS - 1);

    // ------------------------------------------------------------------
    // Step index: a sweep_start coinciding with a dump tags that dump 0.
    // ------------------------------------------------------------------
    logic [STEP_W-1:0] step_cnt_reg;
    logic [STEP_W-1:0] attach_idx;
    logic [STEP_W-1:0] step_cnt_next;

    assign attach_idx    = sweep_start ? '0 : step_cnt_reg;
    assign step_cnt_next = (attach_idx == LAST_IDX) ? '0 : attach_idx + 1'b1;

    // Step counter advances on every dump, dropped or not, to stay frequency aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_reg <= '0;
        end else if (acc_valid) begin
            step_cnt_reg <= step_cnt_next;
        end else if (sweep_start) begin
            step_cnt_reg <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Scaling: floor shift then saturate, one identical lane for I and Q.
    // Lane 0 is I, lane 1 is Q.
    // ------------------------------------------------------------------
    logic [1:0][IN_W-1:0]  acc_in;
    logic [1:0][OUT_W-1:0] sat_val;

    assign acc_in = {acc_q, acc_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [IN_W-1:0] shifted;
            logic                   fits;

            assign shifted = $signed(acc_in[gi]) >>> SHIFT;
            // Value fits when every bit from the output sign bit upward agrees.
            assign fits    = (&shifted[IN_W-1:OUT_W-1]) | ~(|shifted[IN_W-1:OUT_W-1]);
            assign sat_val[gi] = fits ? shifted[OUT_W-1:0]
                                      : (shifted[IN_W-1] ? SAT_MIN : SAT_MAX);
        end
    endgenerate

    logic              s_valid_reg;
    logic [WORD_W-1:0] s_word_reg;

    // Scaled word register: {last, step, I, Q}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_reg <= 1'b0;
            s_word_reg  <= '0;
        end else begin
            s_valid_reg <= acc_valid;
            if (acc_valid) begin
                s_word_reg <= {(attach_idx == LAST_IDX), attach_idx, sat_val[0], sat_val[1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer: RAM behind a FWFT output register. Total occupancy (RAM
    // plus output register) is capped at DEPTH, so the RAM never holds
    // more than DEPTH-1 words.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   mem_cnt_reg;
    logic              out_valid_reg;
    logic [WORD_W-1:0] out_word_reg;
    logic              overflow_reg;

    logic [ADDR_W:0] fill_cnt;
    logic            full;
    logic            xfer;
    logic            out_load;
    logic            wr_en;
    logic            drop;
    logic            bypass;
    logic            mem_wr;
    logic            mem_rd;

    assign fill_cnt = mem_cnt_reg + {{ADDR_W{1'b0}}, out_valid_reg};
    assign full     = (fill_cnt == (ADDR_W+1)'(DEPTH));
    assign xfer     = out_valid_reg & m_ready;
    assign out_load = ~out_valid_reg | xfer;
    assign wr_en    = s_valid_reg & (~full | xfer);
    assign drop     = s_valid_reg & full & ~xfer;
    assign bypass   = wr_en & out_load & (mem_cnt_reg == '0);
    assign mem_wr   = wr_en & ~bypass;
    assign mem_rd   = out_load & (mem_cnt_reg != '0);

    // RAM write port; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= s_word_reg;
        end
    end

    // Pointer and occupancy bookkeeping for the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            mem_cnt_reg <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({mem_wr, mem_rd})
                2'b10:   mem_cnt_reg <= mem_cnt_reg + 1'b1;
                2'b01:   mem_cnt_reg <= mem_cnt_reg - 1'b1;
                default: mem_cnt_reg <= mem_cnt_reg;
            endcase
        end
    end

    // Output register: registered RAM read, or direct bypass when the RAM is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
        end else if (out_load) begin
            if (mem_rd) begin
                out_valid_reg <= 1'b1;
                out_word_reg  <= mem[rd_ptr_reg];
            end else if (bypass) begin
                out_valid_reg <= 1'b1;
                out_word_reg  <= s_word_reg;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Sticky overflow: a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    assign m_valid  = out_valid_reg;
    assign m_last   = out_word_reg[WORD_W-1];
    assign m_step   = out_word_reg[WORD_W-2 -: STEP_W];
    assign m_i      = out_word_reg[2*OUT_W-1 -: OUT_W];
    assign m_q      = out_word_reg[OUT_W-1:0];
    assign fill     = fill_cnt;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_acc_dump_reader.sv
// Testbench for acc_dump_reader: scoreboard of expected words, one task per scenario.
module tb_acc_dump_reader;

    localparam int IN_W    = 48;
    localparam int OUT_W   = 32;
    localparam int SHIFT   = 8;
    localparam int N_STEPS = 64;
    localparam int STEP_W  = 10;
    localparam int ADDR_W  = 6;

    logic              clk;
    logic              rst;
    logic [IN_W-1:0]   acc_i;
    logic [IN_W-1:0]   acc_q;
    logic              acc_valid;
    logic              sweep_start;
    logic              clear_ovf;
    logic [OUT_W-1:0]  m_i;
    logic [OUT_W-1:0]  m_q;
    logic [STEP_W-1:0] m_step;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W:0]   fill;
    logic              overflow;

    typedef struct {
        logic [OUT_W-1:0]  i;
        logic [OUT_W-1:0]  q;
        logic [STEP_W-1:0] step;
        logic              last;
    } word_t;

    word_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    tb_step = 0;

    acc_dump_reader #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .N_STEPS(N_STEPS), .STEP_W(STEP_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .acc_i(acc_i), .acc_q(acc_q),
        .acc_valid(acc_valid), .sweep_start(sweep_start), .clear_ovf(clear_ovf),
        .m_i(m_i), .m_q(m_q), .m_step(m_step), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .fill(fill), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected scaling: floor shift then clamp to the signed output range.
    function automatic logic [OUT_W-1:0] exp_scale(input longint v);
        longint s;
        s = v >>> SHIFT;
        if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) return 32'h8000_0000;
        else                           return s[OUT_W-1:0];
    endfunction

    // Monitor: every transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        word_t e;
        if (!rst && m_valid && m_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word got step=%0d i=%h q=%h required no word", m_step, m_i, m_q);
            end else begin
                e = sb.pop_front();
                if (m_i !== e.i || m_q !== e.q || m_step !== e.step || m_last !== e.last) begin
                    fails++;
                    $display("FAIL word got i=%h q=%h step=%0d last=%b required i=%h q=%h step=%0d last=%b",
                             m_i, m_q, m_step, m_last, e.i, e.q, e.step, e.last);
                end else begin
                    $display("[TB] word i=%h q=%h step=%0d last=%b", m_i, m_q, m_step, m_last);
                end
            end
        end
    end

    // Drive one dump strobe for one cycle; push the expected word when it should be kept.
    task automatic send(input longint vi, input longint vq, input bit ss, input bit push);
        word_t e;
        int idx;
        @(posedge clk); #1;
        acc_i       = vi[IN_W-1:0];
        acc_q       = vq[IN_W-1:0];
        acc_valid   = 1'b1;
        sweep_start = ss;
        idx     = ss ? 0 : tb_step;
        tb_step = (idx + 1) % N_STEPS;
        if (push) begin
            e.i    = exp_scale(vi);
            e.q    = exp_scale(vq);
            e.step = STEP_W'(idx);
            e.last = (idx == N_STEPS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        acc_valid   = 1'b0;
        sweep_start = 1'b0;
        clear_ovf   = 1'b0;
    endtask

    task automatic set_ready(input bit r);
        @(posedge clk); #1;
        m_ready = r;
    endtask

    task automatic pulse_sweep();
        @(posedge clk); #1;
        sweep_start = 1'b1;
        tb_step     = 0;
        idle();
    endtask

    // Wait, bounded, until every expected word is out and the block is empty.
    task automatic drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && fill == 0) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain got pending=%0d fill=%0d required pending=0 fill=0", name, sb.size(), fill);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_i = '0; acc_q = '0; acc_valid = 1'b0;
        sweep_start = 1'b0; clear_ovf = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || m_i !== '0 || m_q !== '0 || m_step !== '0 ||
            m_last !== 1'b0 || fill !== '0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got valid=%b i=%h q=%h step=%0d last=%b fill=%0d ovf=%b required all zero",
                     m_valid, m_i, m_q, m_step, m_last, fill, overflow);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        set_ready(1'b1);
        pulse_sweep();
        send(64'sh12300, -64'sh12300, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_t1 got m_valid=%b required 0", m_valid);
        end
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || fill !== 7'd1) begin
            fails++;
            $display("FAIL latency_t2 got m_valid=%b fill=%0d required m_valid=1 fill=1", m_valid, fill);
        end
        @(negedge clk);
        tests++;
        if (fill !== 7'd0) begin
            fails++;
            $display("FAIL basic_fill got %0d required 0", fill);
        end
        drain("basic");
    endtask

    task automatic test_saturate();
        send(64'sh4000_0000_0000, -64'sh4000_0000_0000, 1'b0, 1'b1);
        send(-64'sd1, 64'sd255, 1'b0, 1'b1);
        send(64'sh7FFF_FFFF_FF, -64'sh8000_0000_00, 1'b0, 1'b1);
        idle();
        drain("saturate");
    endtask

    task automatic test_wrap();
        pulse_sweep();
        for (int n = 0; n < 130; n++) begin
            send(longint'(n) <<< 12, -(longint'(n) <<< 9), 1'b0, 1'b1);
        end
        idle();
        drain("wrap");
    endtask

    task automatic test_overflow();
        set_ready(1'b0);
        pulse_sweep();
        for (int n = 0; n < 70; n++) begin
            send(longint'(n + 1) <<< SHIFT, longint'(n) <<< 4, 1'b0, n < 64);
        end
        idle();
        repeat (3) @(negedge clk);
        tests++;
        if (fill !== 7'd64 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_full got fill=%0d ovf=%b required fill=64 ovf=1", fill, overflow);
        end
        set_ready(1'b1);
        drain("overflow");
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky got %b required 1", overflow);
        end
        @(posedge clk); #1 clear_ovf = 1'b1;
        idle();
        @(negedge clk);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_clear got %b required 0", overflow);
        end
    endtask

    task automatic test_full_xfer();
        logic [OUT_W-1:0]  hi, hq;
        logic [STEP_W-1:0] hs;
        set_ready(1'b0);
        for (int n = 0; n < 64; n++) begin
            send(-(longint'(n) <<< 10), longint'(n) <<< 20, n == 0, 1'b1);
        end
        idle();
        repeat (2) @(negedge clk);
        tests++;
        if (fill !== 7'd64) begin
            fails++;
            $display("FAIL full_before got fill=%0d required 64", fill);
        end
        // Strobe in cycle t, transfer exactly in cycle t+1 when the word is written.
        send(64'sh5500, 64'sh6600, 1'b0, 1'b1);
        @(posedge clk); #1;
        acc_valid = 1'b0;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (fill !== 7'd64 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_xfer got fill=%0d ovf=%b required fill=64 ovf=0", fill, overflow);
        end
        hi = m_i; hq = m_q; hs = m_step;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b1 || m_i !== hi || m_q !== hq || m_step !== hs) begin
                fails++;
                $display("FAIL stall_hold got valid=%b i=%h q=%h step=%0d required valid=1 i=%h q=%h step=%0d",
                         m_valid, m_i, m_q, m_step, hi, hq, hs);
            end
        end
        set_ready(1'b1);
        drain("full_xfer");
    endtask

    task automatic test_reset_mid();
        set_ready(1'b0);
        for (int n = 0; n < 20; n++) begin
            send(longint'(n) <<< 8, longint'(n) <<< 8, 1'b0, 1'b1);
        end
        idle();
        repeat (2) @(negedge clk);
        tests++;
        if (fill !== 7'd20) begin
            fails++;
            $display("FAIL mid_fill got %0d required 20", fill);
        end
        @(posedge clk); #3 rst = 1'b1;
        #1;
        tests++;
        if (m_valid !== 1'b0 || fill !== '0) begin
            fails++;
            $display("FAIL mid_reset got m_valid=%b fill=%0d required 0 0", m_valid, fill);
        end
        sb.delete();
        tb_step = 0;
        @(posedge clk); #1 rst = 1'b0;
        set_ready(1'b1);
        send(64'sh777700, 64'sh888800, 1'b0, 1'b1);
        idle();
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_wrap();
        test_overflow();
        test_full_xfer();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
